// File: rtl/fcc_pkg.sv
// Shared definitions for the fully-connected layer engine: FSM states,
// datapath widths and memory transfer sizes.
package fcc_pkg;

  localparam int unsigned DP_DEPTH   = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = DP_DEPTH * BYTE_W;
  localparam int unsigned PROD_W     = 17;
  localparam int unsigned SUM_W      = 22;
  localparam int unsigned SIZE_W     = 6;
  localparam int unsigned BIAS_BYTES = 4;
  localparam int unsigned LINE_BYTES = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS_RD,
    S_PIC_RD,
    S_WGT_RD,
    S_MAC,
    S_WRITE,
    S_DONE
  } fcc_state_e;

endpackage

// File: rtl/fcc_engine_if.sv
// Memory-side bundle of the engine: three read channels (pic, wgt, bias)
// and one write channel. master = engine side, slave = arbiter side.
interface fcc_engine_if #(
  parameter int unsigned ADDR_WIDTH = 19
);
  import fcc_pkg::*;

  logic                  pic_mem_req;
  logic [ADDR_WIDTH-1:0] pic_mem_start_addr;
  logic [SIZE_W-1:0]     pic_mem_size_bytes;
  logic                  pic_mem_valid;
  logic [LINE_W-1:0]     pic_mem_data;

  logic                  wgt_mem_req;
  logic [ADDR_WIDTH-1:0] wgt_mem_start_addr;
  logic [SIZE_W-1:0]     wgt_mem_size_bytes;
  logic                  wgt_mem_valid;
  logic [LINE_W-1:0]     wgt_mem_data;

  logic                  bias_mem_req;
  logic [ADDR_WIDTH-1:0] bias_mem_start_addr;
  logic [SIZE_W-1:0]     bias_mem_size_bytes;
  logic                  bias_mem_valid;
  logic [WORD_W-1:0]     bias_mem_data;

  logic                  wr_mem_req;
  logic [ADDR_WIDTH-1:0] wr_mem_start_addr;
  logic [WORD_W-1:0]     wr_mem_data;
  logic                  wr_mem_ack;

  modport master (
    output pic_mem_req, pic_mem_start_addr, pic_mem_size_bytes,
    input  pic_mem_valid, pic_mem_data,
    output wgt_mem_req, wgt_mem_start_addr, wgt_mem_size_bytes,
    input  wgt_mem_valid, wgt_mem_data,
    output bias_mem_req, bias_mem_start_addr, bias_mem_size_bytes,
    input  bias_mem_valid, bias_mem_data,
    output wr_mem_req, wr_mem_start_addr, wr_mem_data,
    input  wr_mem_ack
  );

  modport slave (
    input  pic_mem_req, pic_mem_start_addr, pic_mem_size_bytes,
    output pic_mem_valid, pic_mem_data,
    input  wgt_mem_req, wgt_mem_start_addr, wgt_mem_size_bytes,
    output wgt_mem_valid, wgt_mem_data,
    input  bias_mem_req, bias_mem_start_addr, bias_mem_size_bytes,
    output bias_mem_valid, bias_mem_data,
    input  wr_mem_req, wr_mem_start_addr, wr_mem_data,
    output wr_mem_ack
  );

endinterface

// File: rtl/fcc_dot32.sv
// 32-lane dot product: unsigned data bytes times signed weight bytes,
// reduced by a balanced adder tree to a 22-bit signed sum.
module fcc_dot32
  import fcc_pkg::*;
(
  input  logic [LINE_W-1:0]       i_x,
  input  logic [LINE_W-1:0]       i_w,
  output logic signed [SUM_W-1:0] o_sum
);

  // Products feed leaves DP_DEPTH-1..2*DP_DEPTH-2 of a heap-ordered tree; node 0 is the root.
  always_comb begin
    logic signed [PROD_W-1:0] xs;
    logic signed [PROD_W-1:0] ws;
    logic signed [SUM_W-1:0]  node [2*DP_DEPTH-1];
    node = '{default: '0};
    xs   = '0;
    ws   = '0;
    for (int unsigned j = 0; j < DP_DEPTH; j++) begin
      xs = PROD_W'($signed({1'b0, i_x[BYTE_W*j +: BYTE_W]}));
      ws = PROD_W'($signed(i_w[BYTE_W*j +: BYTE_W]));
      node[DP_DEPTH-1+j] = SUM_W'(xs * ws);
    end
    for (int unsigned i = DP_DEPTH - 1; i >= 1; i--) begin
      node[i-1] = node[2*i-1] + node[2*i];
    end
    o_sum = node[0];
  end

endmodule

// File: rtl/fcc_engine.sv
// Fully-connected layer engine. For each output neuron: read bias, then
// stream input/weight lines through a 32-lane MAC, then write the result.
// Optional build macro FCC_RELU_EN: clamp negative results to zero on write.
module fcc_engine #(
  parameter int unsigned DP_DEPTH   = 32,
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned X_ROWS_NUM = 128,
  parameter int unsigned Y_ROWS_NUM = 128,
  parameter int unsigned CNT_W      = $clog2(X_ROWS_NUM) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fc_go,
  input  logic [ADDR_WIDTH-1:0] fc_addrx,
  input  logic [ADDR_WIDTH-1:0] fc_addry,
  input  logic [ADDR_WIDTH-1:0] fc_addrb,
  input  logic [ADDR_WIDTH-1:0] fc_addrz,
  input  logic [CNT_W-1:0]      fc_xm,
  input  logic [CNT_W-1:0]      fc_ym,
  input  logic [CNT_W-1:0]      fc_yn,
  input  logic [CNT_W-1:0]      cnn_bn,
  output logic                  fc_sw_busy_ind,
  output logic                  fc_done,
  fcc_engine_if.master          mem
);
  import fcc_pkg::*;

  fcc_state_e              r_state;
  fcc_state_e              w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addrx, r_addry, r_addrb, r_addrz;
  logic [CNT_W-1:0]        r_xm, r_ym, r_n, r_k;
  logic signed [WORD_W-1:0] r_acc;
  logic [LINE_W-1:0]       r_pic, r_wgt;

  logic signed [SUM_W-1:0]  w_dot;
  logic signed [WORD_W-1:0] w_result;
  logic [ADDR_WIDTH-1:0]    w_line_off, w_word_off;
  logic [ADDR_WIDTH-1:0]    w_bias_addr, w_pic_addr, w_wgt_addr, w_wr_addr;
  logic [31:0]              w_next_bytes, w_next_n;
  logic                     w_more_lines, w_more_neurons;
  logic                     w_unused;

  // fc_yn only mirrors fc_xm and cnn_bn is reserved.
  assign w_unused = ^{fc_yn, cnn_bn};

  fcc_dot32 u_dot (
    .i_x   (r_pic),
    .i_w   (r_wgt),
    .o_sum (w_dot)
  );

  // Address generation and loop-termination tests.
  always_comb begin
    w_line_off     = ADDR_WIDTH'(r_k) * ADDR_WIDTH'(DP_DEPTH);
    w_word_off     = ADDR_WIDTH'(r_n) * ADDR_WIDTH'(BIAS_BYTES);
    w_bias_addr    = r_addrb + w_word_off;
    w_pic_addr     = r_addrx + w_line_off;
    w_wgt_addr     = r_addry + ADDR_WIDTH'(r_n) * ADDR_WIDTH'(r_xm) + w_line_off;
    w_wr_addr      = r_addrz + w_word_off;
    w_next_bytes   = (32'(r_k) + 32'd1) * DP_DEPTH;
    w_next_n       = 32'(r_n) + 32'd1;
    w_more_lines   = (w_next_bytes < 32'(r_xm)) && (w_next_bytes < X_ROWS_NUM);
    w_more_neurons = (w_next_n < 32'(r_ym)) && (w_next_n < Y_ROWS_NUM);
  end

  // Optional ReLU on the written result.
  always_comb begin
`ifdef FCC_RELU_EN
    w_result = r_acc[WORD_W-1] ? '0 : r_acc;
`else
    w_result = r_acc;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and bus outputs; a request is held for the whole state so it stays up until valid/ack.
  always_comb begin
    w_state_nxt             = r_state;
    fc_sw_busy_ind          = 1'b1;
    fc_done                 = 1'b0;
    mem.bias_mem_req        = 1'b0;
    mem.bias_mem_start_addr = '0;
    mem.bias_mem_size_bytes = '0;
    mem.pic_mem_req         = 1'b0;
    mem.pic_mem_start_addr  = '0;
    mem.pic_mem_size_bytes  = '0;
    mem.wgt_mem_req         = 1'b0;
    mem.wgt_mem_start_addr  = '0;
    mem.wgt_mem_size_bytes  = '0;
    mem.wr_mem_req          = 1'b0;
    mem.wr_mem_start_addr   = '0;
    mem.wr_mem_data         = '0;
    unique case (r_state)
      S_IDLE: begin
        fc_sw_busy_ind = 1'b0;
        if (fc_go) w_state_nxt = S_BIAS_RD;
      end
      S_BIAS_RD: begin
        mem.bias_mem_req        = 1'b1;
        mem.bias_mem_start_addr = w_bias_addr;
        mem.bias_mem_size_bytes = SIZE_W'(BIAS_BYTES);
        if (mem.bias_mem_valid) w_state_nxt = S_PIC_RD;
      end
      S_PIC_RD: begin
        mem.pic_mem_req        = 1'b1;
        mem.pic_mem_start_addr = w_pic_addr;
        mem.pic_mem_size_bytes = SIZE_W'(LINE_BYTES);
        if (mem.pic_mem_valid) w_state_nxt = S_WGT_RD;
      end
      S_WGT_RD: begin
        mem.wgt_mem_req        = 1'b1;
        mem.wgt_mem_start_addr = w_wgt_addr;
        mem.wgt_mem_size_bytes = SIZE_W'(LINE_BYTES);
        if (mem.wgt_mem_valid) w_state_nxt = S_MAC;
      end
      S_MAC: begin
        w_state_nxt = w_more_lines ? S_PIC_RD : S_WRITE;
      end
      S_WRITE: begin
        mem.wr_mem_req        = 1'b1;
        mem.wr_mem_start_addr = w_wr_addr;
        mem.wr_mem_data       = w_result;
        if (mem.wr_mem_ack) w_state_nxt = w_more_neurons ? S_BIAS_RD : S_DONE;
      end
      S_DONE: begin
        fc_done     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Configuration latch, line capture, accumulator and neuron/line counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addrx <= '0;
      r_addry <= '0;
      r_addrb <= '0;
      r_addrz <= '0;
      r_xm    <= '0;
      r_ym    <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_pic   <= '0;
      r_wgt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (fc_go) begin
            r_addrx <= fc_addrx;
            r_addry <= fc_addry;
            r_addrb <= fc_addrb;
            r_addrz <= fc_addrz;
            r_xm    <= fc_xm;
            r_ym    <= fc_ym;
            r_n     <= '0;
            r_k     <= '0;
          end
        end
        S_BIAS_RD: if (mem.bias_mem_valid) r_acc <= $signed(mem.bias_mem_data);
        S_PIC_RD:  if (mem.pic_mem_valid)  r_pic <= mem.pic_mem_data;
        S_WGT_RD:  if (mem.wgt_mem_valid)  r_wgt <= mem.wgt_mem_data;
        S_MAC: begin
          r_acc <= r_acc + WORD_W'(w_dot);
          r_k   <= r_k + CNT_W'(1);
        end
        S_WRITE: begin
          if (mem.wr_mem_ack) begin
            r_n <= r_n + CNT_W'(1);
            r_k <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fcc_engine.sv
`timescale 1ns/1ps
// Testbench for fcc_engine: byte-addressed memory responder with optional
// random wait states, directed vector table and randomized jobs checked
// against a plain-arithmetic reference of the layer computation.
module tb_fcc_engine;
  localparam int unsigned AW = 19;
  localparam int unsigned CW = 8;
  localparam int JOB_BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fc_go = 1'b0;
  logic [AW-1:0] fc_addrx, fc_addry, fc_addrb, fc_addrz;
  logic [CW-1:0] fc_xm, fc_ym, fc_yn, cnn_bn;
  logic          fc_sw_busy_ind, fc_done;

  fcc_engine_if #(.ADDR_WIDTH(AW)) mif ();

  fcc_engine #(
    .DP_DEPTH(32), .ADDR_WIDTH(AW), .X_ROWS_NUM(128), .Y_ROWS_NUM(128), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fc_go(fc_go),
    .fc_addrx(fc_addrx), .fc_addry(fc_addry), .fc_addrb(fc_addrb), .fc_addrz(fc_addrz),
    .fc_xm(fc_xm), .fc_ym(fc_ym), .fc_yn(fc_yn), .cnn_bn(cnn_bn),
    .fc_sw_busy_ind(fc_sw_busy_ind), .fc_done(fc_done),
    .mem(mif.master)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<AW)-1];

  typedef struct { int unsigned ch; logic [AW-1:0] addr; } rd_t;
  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  rd_t rd_log[$];
  wr_t wr_log[$];

  int errors = 0;
  int checks = 0;
  int proto_err = 0;
  int wgt_served = 0;
  int unsigned max_dly = 0;
  int unsigned wr_dly = 0;
  bit stray_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] line_at(input logic [AW-1:0] a);
    logic [255:0] l;
    for (int j = 0; j < 32; j++) l[8*j +: 8] = mem[a + AW'(j)];
    return l;
  endfunction

  function automatic int unsigned active_ch();
    if (mif.bias_mem_req) return 0;
    if (mif.pic_mem_req)  return 1;
    if (mif.wgt_mem_req)  return 2;
    if (mif.wr_mem_req)   return 3;
    return 4;
  endfunction

  function automatic bit req_of(input int unsigned ch);
    case (ch)
      0: return mif.bias_mem_req;
      1: return mif.pic_mem_req;
      2: return mif.wgt_mem_req;
      3: return mif.wr_mem_req;
      default: return 1'b0;
    endcase
  endfunction

  task automatic serve(input int unsigned ch);
    logic [AW-1:0] a;
    case (ch)
      0: begin
        a = mif.bias_mem_start_addr;
        if (mif.bias_mem_size_bytes != 6'd4) proto_err++;
        rd_log.push_back('{0, a});
        mif.bias_mem_data  = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
        mif.bias_mem_valid = 1'b1;
      end
      1: begin
        a = mif.pic_mem_start_addr;
        if (mif.pic_mem_size_bytes != 6'd32) proto_err++;
        rd_log.push_back('{1, a});
        mif.pic_mem_data  = line_at(a);
        mif.pic_mem_valid = 1'b1;
      end
      2: begin
        a = mif.wgt_mem_start_addr;
        if (mif.wgt_mem_size_bytes != 6'd32) proto_err++;
        rd_log.push_back('{2, a});
        mif.wgt_mem_data  = line_at(a);
        mif.wgt_mem_valid = 1'b1;
        wgt_served++;
      end
      default: begin
        wr_log.push_back('{mif.wr_mem_start_addr, mif.wr_mem_data});
        mif.wr_mem_ack = 1'b1;
      end
    endcase
  endtask

  // Memory responder: one-cycle valid/ack pulses after a per-request wait,
  // optional stray valids on a non-requested read channel while waiting.
  initial begin : responder
    bit pend;
    int unsigned dly, ch, nreq;
    pend = 1'b0; dly = 0; ch = 4;
    mif.pic_mem_valid = 1'b0; mif.wgt_mem_valid = 1'b0; mif.bias_mem_valid = 1'b0;
    mif.wr_mem_ack = 1'b0;
    mif.pic_mem_data = '0; mif.wgt_mem_data = '0; mif.bias_mem_data = '0;
    forever begin
      @(posedge clk); #1;
      mif.pic_mem_valid = 1'b0; mif.wgt_mem_valid = 1'b0;
      mif.bias_mem_valid = 1'b0; mif.wr_mem_ack = 1'b0;
      nreq = 32'(mif.bias_mem_req) + 32'(mif.pic_mem_req) + 32'(mif.wgt_mem_req) + 32'(mif.wr_mem_req);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (nreq > 1) proto_err++;
        if (pend && !req_of(ch)) begin proto_err++; pend = 1'b0; end
        if (!pend && nreq != 0) begin
          ch   = active_ch();
          pend = 1'b1;
          dly  = (ch == 3) ? wr_dly : (max_dly != 0 ? $urandom_range(max_dly, 0) : 0);
        end
        if (pend) begin
          if (dly == 0) begin
            serve(ch);
            pend = 1'b0;
          end else begin
            dly--;
            if (stray_en && ch == 0) begin mif.pic_mem_valid = 1'b1; mif.pic_mem_data = {8{$urandom()}}; end
            if (stray_en && ch == 1) begin mif.wgt_mem_valid = 1'b1; mif.wgt_mem_data = {8{$urandom()}}; end
            if (stray_en && ch == 2) begin mif.pic_mem_valid = 1'b1; mif.pic_mem_data = {8{$urandom()}}; end
          end
        end
      end
    end
  end

  // Reference: bias + sum of x[i]*w[n][i] in wide arithmetic, wrapped to 32 bits.
  function automatic logic [31:0] ref_neuron(input int n, input int xm);
    int ax, ay, ab;
    longint acc;
    logic [31:0] r;
    ax = int'(fc_addrx); ay = int'(fc_addry); ab = int'(fc_addrb);
    acc = longint'($signed({mem[ab+4*n+3], mem[ab+4*n+2], mem[ab+4*n+1], mem[ab+4*n]}));
    for (int i = 0; i < xm; i++)
      acc += longint'(mem[ax+i]) * longint'($signed(mem[ay+n*xm+i]));
    r = acc[31:0];
`ifdef FCC_RELU_EN
    if (r[31]) r = '0;
`endif
    return r;
  endfunction

  function automatic logic [31:0] relu_adj(input logic [31:0] v);
`ifdef FCC_RELU_EN
    return v[31] ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic fill_const(input int xm, input int ym, input logic [7:0] xv,
                            input logic [7:0] wv, input logic [31:0] b);
    for (int i = 0; i < xm; i++) mem[int'(fc_addrx)+i] = xv;
    for (int i = 0; i < xm*ym; i++) mem[int'(fc_addry)+i] = wv;
    for (int n = 0; n < ym; n++)
      for (int j = 0; j < 4; j++) mem[int'(fc_addrb)+4*n+j] = b[8*j +: 8];
  endtask

  task automatic fill_rand(input int xm, input int ym);
    for (int i = 0; i < xm; i++) mem[int'(fc_addrx)+i] = 8'($urandom());
    for (int i = 0; i < xm*ym; i++) mem[int'(fc_addry)+i] = 8'($urandom());
    for (int i = 0; i < 4*ym; i++) mem[int'(fc_addrb)+i] = 8'($urandom());
  endtask

  task automatic chk_quiet_outs(input string tag);
    chk({tag, " ctl"}, {fc_sw_busy_ind, fc_done, mif.bias_mem_req, mif.pic_mem_req,
                        mif.wgt_mem_req, mif.wr_mem_req}, 64'd0);
    chk({tag, " bus"}, 64'(|{mif.bias_mem_start_addr, mif.pic_mem_start_addr, mif.wgt_mem_start_addr,
                             mif.wr_mem_start_addr, mif.bias_mem_size_bytes, mif.pic_mem_size_bytes,
                             mif.wgt_mem_size_bytes, mif.wr_mem_data}), 64'd0);
  endtask

  // Run one job to completion and compare writes, read sequence, protocol and timing.
  task automatic run_job(input string tag, input int xm, input int ym, input bit chk_lat);
    rd_t exp_r[$];
    wr_t exp_w[$];
    int cyc, mis, first;
    for (int n = 0; n < ym; n++) begin
      exp_r.push_back('{0, AW'(int'(fc_addrb) + 4*n)});
      for (int k = 0; k < xm/32; k++) begin
        exp_r.push_back('{1, AW'(int'(fc_addrx) + 32*k)});
        exp_r.push_back('{2, AW'(int'(fc_addry) + n*xm + 32*k)});
      end
      exp_w.push_back('{AW'(int'(fc_addrz) + 4*n), ref_neuron(n, xm)});
    end
    rd_log.delete(); wr_log.delete(); proto_err = 0;
    fc_xm = CW'(xm); fc_ym = CW'(ym); fc_yn = CW'(xm); cnn_bn = CW'($urandom());
    fc_go = 1'b1;
    @(posedge clk); #1;
    fc_go = 1'b0;
    chk({tag, " busy_after_go"}, fc_sw_busy_ind, 1);
    cyc = 1;
    while (!fc_done && cyc < JOB_BUDGET) begin @(posedge clk); #1; cyc++; end
    chk({tag, " done_seen"}, fc_done, 1);
    chk({tag, " busy_in_done"}, fc_sw_busy_ind, 1);
    if (chk_lat) chk({tag, " latency"}, 64'(cyc), 64'(ym*(2 + 3*(xm/32)) + 1));
    @(posedge clk); #1;
    chk({tag, " done_pulse_ends"}, fc_done, 0);
    chk({tag, " idle_busy"}, fc_sw_busy_ind, 0);
    chk({tag, " wr_count"}, 64'(wr_log.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++) begin
      chk($sformatf("%s wr%0d_addr", tag, i), 64'(wr_log[i].addr), 64'(exp_w[i].addr));
      chk($sformatf("%s wr%0d_data", tag, i), 64'(wr_log[i].data), 64'(exp_w[i].data));
    end
    mis = (rd_log.size() != exp_r.size()) ? 1 : 0;
    first = -1;
    for (int i = 0; i < exp_r.size() && i < rd_log.size(); i++)
      if (rd_log[i].ch != exp_r[i].ch || rd_log[i].addr !== exp_r[i].addr) begin
        if (first < 0) first = i;
        mis++;
      end
    if (first >= 0)
      $display("  %s first read difference at %0d: ch%0d @0x%0h vs ch%0d @0x%0h", tag, first,
               rd_log[first].ch, rd_log[first].addr, exp_r[first].ch, exp_r[first].addr);
    chk({tag, " read_seq_mismatches"}, 64'(mis), 64'd0);
    chk({tag, " protocol_errors"}, 64'(proto_err), 64'd0);
  endtask

  typedef struct {
    int          xm;
    int          ym;
    logic [7:0]  xv;
    logic [7:0]  wv;
    logic [31:0] bias;
    logic [31:0] exp_raw;
  } vec_t;

  initial begin : main
    vec_t vecs [4];
    int   c, w0;

    vecs[0] = '{32,  1, 8'd1,   8'd2,   32'd5,          32'd69};
    vecs[1] = '{32,  1, 8'd255, 8'h80,  32'd0,          32'hFFF0_1000};  // -1044480
    vecs[2] = '{128, 3, 8'd3,   8'hFF,  32'd100,        32'hFFFF_FEE4};  // -284
    vecs[3] = '{64,  2, 8'd200, 8'd127, 32'h7FFF_FF00,  32'h8018_CD00};  // wraps past +2^31

    fc_addrx = 19'h01000; fc_addry = 19'h10000; fc_addrb = 19'h20000; fc_addrz = 19'h30000;
    fc_xm = 8'd32; fc_ym = 8'd1; fc_yn = 8'd32; cnn_bn = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet_outs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_go busy", fc_sw_busy_ind, 0);

    for (int v = 0; v < 4; v++) begin
      fill_const(vecs[v].xm, vecs[v].ym, vecs[v].xv, vecs[v].wv, vecs[v].bias);
      run_job($sformatf("vec%0d", v), vecs[v].xm, vecs[v].ym, 1'b1);
      for (int n = 0; n < vecs[v].ym && n < wr_log.size(); n++)
        chk($sformatf("vec%0d table_result%0d", v, n), 64'(wr_log[n].data), 64'(relu_adj(vecs[v].exp_raw)));
    end

    fill_rand(128, 128);
    run_job("rand128x128", 128, 128, 1'b1);

    max_dly = 5; wr_dly = 3; stray_en = 1'b1;
    fill_rand(96, 6);
    run_job("delayed", 96, 6, 1'b0);
    fill_rand(32, 3);
    run_job("delayed_short", 32, 3, 1'b0);
    max_dly = 0; wr_dly = 0; stray_en = 1'b0;

    // Abort with reset during the first MAC of neuron 2.
    fill_rand(64, 4);
    rd_log.delete(); wr_log.delete();
    fc_xm = 8'd64; fc_ym = 8'd4; fc_yn = 8'd64;
    fc_go = 1'b1;
    @(posedge clk); #1;
    fc_go = 1'b0;
    c = 0;
    while (wr_log.size() < 2 && c < JOB_BUDGET) begin @(posedge clk); #2; c++; end
    chk("abort two_writes_before", 64'(wr_log.size()), 64'd2);
    w0 = wgt_served;
    c = 0;
    while (wgt_served == w0 && c < JOB_BUDGET) begin @(posedge clk); #2; c++; end
    chk("abort wgt_line_served", 64'(wgt_served - w0), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_quiet_outs("abort_next_cycle");
    repeat (3) begin @(posedge clk); #1; end
    chk("abort no_more_writes", 64'(wr_log.size()), 64'd2);
    chk_quiet_outs("abort_held");
    rst_n = 1'b1;
    @(posedge clk); #1;

    fc_addrx = 19'h04460; fc_addry = 19'h18000; fc_addrb = 19'h24004; fc_addrz = 19'h3A000;
    fill_rand(128, 5);
    run_job("after_abort", 128, 5, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fcc_engine.md
Name: fcc_engine

Overview:
- Fully-connected layer engine for the accelerator datapath.
- Per output neuron n: fetches one 32-bit bias, then streams fc_xm input bytes (unsigned) and the matching fc_xm weight bytes (signed) in 32-byte lines.
- Accumulates bias + sum(x[i]*w[n][i]) and writes one 32-bit result word.
- Sits between the software register block and the memory arbiter: three read request channels (pic, wgt, bias) and one write channel.

Parameters:
- DP_DEPTH, 32: bytes per memory line and per MAC step.
- ADDR_WIDTH, 19: byte-address width.
- X_ROWS_NUM, 128: maximum input vector length.
- Y_ROWS_NUM, 128: maximum number of output neurons.
- CNT_W, $clog2(X_ROWS_NUM)+1: width of the count registers; the full value 128 must be representable.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: synchronous active-low reset.
- fc_go, in, 1: start request.
- fc_addrx / fc_addry / fc_addrb / fc_addrz, in, ADDR_WIDTH each: base addresses of data, weights, bias and result.
- fc_xm, in, CNT_W: input length; multiple of 32, 32..X_ROWS_NUM.
- fc_ym, in, CNT_W: number of output neurons, 1..Y_ROWS_NUM.
- fc_yn, in, CNT_W: weight columns; must equal fc_xm; not otherwise used.
- cnn_bn, in, CNT_W: reserved; ignored.
- fc_sw_busy_ind, out, 1: engine busy.
- fc_done, out, 1: one-cycle completion pulse.
- {pic,wgt,bias}_mem_req, out, 1: read requests.
- {pic,wgt,bias}_mem_start_addr, out, ADDR_WIDTH: read addresses.
- {pic,wgt,bias}_mem_size_bytes, out, 6: read size (32 for pic/wgt, 4 for bias).
- {pic,wgt,bias}_mem_valid, in, 1: read data valid.
- pic_mem_data, in, 256: 32 unsigned bytes.
- wgt_mem_data, in, 256: 32 signed bytes.
- bias_mem_data, in, 32: signed bias.
- wr_mem_req, out, 1: write request.
- wr_mem_start_addr, out, ADDR_WIDTH: write address.
- wr_mem_data, out, 32: result word.
- wr_mem_ack, in, 1: write accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, FSM to IDLE, accumulator and counters cleared. Reset mid-operation aborts with no write and no done pulse.
- FSM states: IDLE, BIAS_RD, PIC_RD, WGT_RD, MAC, WRITE, DONE.
- IDLE: fc_go=1 latches all configuration inputs, clears n and k, then goes to BIAS_RD. fc_sw_busy_ind is 1 from the cycle after the go sample until the DONE cycle inclusive.
- BIAS_RD: bias_mem_req=1, address = fc_addrb + 4n. Held until bias_mem_valid; on valid, acc <= sign-extended bias, go to PIC_RD.
- PIC_RD: pic_mem_req=1, address = fc_addrx + 32k. Held until valid; line captured, go to WGT_RD.
- WGT_RD: wgt_mem_req=1, address = fc_addry + n*fc_xm + 32k. Held until valid; line captured, go to MAC.
- Request/valid rules: a request stays high until its valid arrives. Valid is honoured only in the matching state; valid in any other state is ignored. At most one request is active at a time.
- MAC, one cycle:
  - acc += sum over j=0..31 of $signed({1'b0,x[j]}) * $signed(w[j]).
  - Products are 17-bit signed; the tree sum is 22-bit; the accumulator is 32-bit signed and wraps on overflow.
  - Then k++. If 32(k+1) < fc_xm go to PIC_RD, else go to WRITE.
- WRITE: wr_mem_req=1, address = fc_addrz + 4n, data = acc. Held until wr_mem_ack.
  - On ack: n++, k=0.
  - If n+1 < fc_ym go to BIAS_RD, else go to DONE.
- DONE: fc_done=1 for one cycle, then IDLE. fc_go still high in IDLE restarts immediately.
- Latency per neuron: 1 (bias) + fc_xm/32 × 3 cycles minimum, plus 1 (write) with zero-wait memories.
- Byte j of a line is bits [8j+7:8j].

Optional Feature:
- FCC_RELU_EN defined: wr_mem_data = acc<0 ? 0 : acc.
- Not defined: raw 32-bit signed accumulator is written.
- No other behaviour or timing difference.

Decomposition:
- Package fcc_pkg holds: the FSM state enum, DP_DEPTH, byte/word width constants, and the bias (4) and line (32) size constants.
- One sub-module, fcc_dot32: combinational 32-lane unsigned×signed multiply with an adder tree producing a 22-bit signed sum.

Test Plan:
- Single neuron, fc_xm=32, fc_ym=1, bias=5, all x=1, w=2 -> one write of 69 to fc_addrz, then fc_done pulse, then busy=0.
- Signed mix: x=255, w=-128, 32 lanes, bias=0 -> result -1044480. With FCC_RELU_EN -> 0.
- 128×128 from generated data/weights/bias files:
  - 128 writes at addrz+4n matching the reference results.
  - Request addresses: pic = addrx+32k; wgt = addry+128n+32k; bias = addrb+4n.
- Delayed valids (0–5 random wait cycles) and write ack delayed 3 cycles -> identical results; requests stay high until valid/ack.
- rst_n=0 during MAC of neuron 2 -> outputs 0 the next cycle, no further writes. A new fc_go then completes a full correct run.
- Stray pic_mem_valid in BIAS_RD -> ignored; results unchanged.
